lieat_ifu_pcgen: RTL and testbench
==================================

Name: lieat_ifu_pcgen

Overview:
- Parametrised next-generation PC generator for the lieat IFU.
- Computes and registers the fetch PC each cycle from reset, flush, sequential and redirect sources.
- Adds what the single-width AGU lacked:
  - a 2-bit branch history table (BHT) for conditional-branch direction;
  - a return address stack (RAS), so returns do not stall on jalr register dependencies.
- Sits between IFU decode-lite and the fetch request path; the EXU feeds back branch outcomes.

Parameters:
- XLEN, 32, datapath/PC width.
- PC_DEFAULT, 32'h8000_0000, PC loaded on reset.
- RAS_DEPTH, 4, return stack entries (power of 2, >=2).
- BHT_IDX_W, 4, BHT index width; 2**BHT_IDX_W entries.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_req  in  1  redirect from EXU/commit.
- flush_pc  in  XLEN  redirect target.
- ifetch_req  in  1  fetch stage requests PC advance this cycle.
- dec_vld  in  1  decode fields below are valid for current pc.
- inst_jal, inst_jalr, inst_bxx, inst_ecall, inst_mret  in  1 each  instruction class.
- inst_call  in  1  jal/jalr with rd in {x1,x5}.
- inst_ret  in  1  jalr with rs1 in {x1,x5}, rd=x0.
- imm_branch  in  XLEN  sign-extended branch/jump offset.
- ifu_csr_rdata  in  XLEN  mtvec (ecall) / mepc (mret).
- jalr_dep  in  1  jalr rs1 has an outstanding write.
- jalr_src1  in  XLEN  jalr rs1 value.
- bht_upd_vld  in  1  resolved conditional branch.
- bht_upd_pc  in  XLEN  PC of resolved branch.
- bht_upd_taken  in  1  resolved direction.
- pc  out  XLEN  registered fetch PC.
- prdt_taken  out  1  redirect predicted for current pc.
- jalr_need_wait  out  1  PC held for jalr dependency.
- ras_used  out  1  current return target taken from RAS.
- ras_empty  out  1  RAS count == 0.

Behaviour:
- Reset, synchronous, applied at the clock edge while rst=1:
  - pc=PC_DEFAULT; RAS count=0, top pointer=0; all BHT counters=2'b01 (weakly not-taken).
  - rst has priority over every other input in that cycle.
- Combinational outputs:
  - bht_tkn = BHT[pc[BHT_IDX_W+1:2]][1].
  - ras_used = dec_vld & inst_ret & ~ras_empty.
  - prdt_taken = dec_vld & (inst_jal | inst_jalr | inst_ecall | inst_mret | (inst_bxx & bht_tkn)).
  - jalr_need_wait = dec_vld & inst_jalr & ~ras_used & jalr_dep.
- Advance: adv = ifetch_req & ~jalr_need_wait & ~flush_req & ~rst.
- Target selection when prdt_taken:
  - ecall/mret: ifu_csr_rdata.
  - ras_used: RAS top entry.
  - jal/bxx: pc + imm_branch.
  - jalr otherwise: jalr_src1 + imm_branch.
  - When not taken: pc + 4.
  - Result bit0 forced to 0. Arithmetic modulo 2**XLEN; wrap-around allowed, no flag.
- pc register, next-value priority:
  1. rst: PC_DEFAULT.
  2. flush_req: flush_pc.
  3. adv: computed target.
  4. Otherwise: hold. A held PC while jalr_need_wait=1 repeats identically each cycle until jalr_dep drops.
- RAS updates only on adv with dec_vld:
  - Push (inst_call & ~inst_ret): write pc+4 at top+1, top increments mod RAS_DEPTH, count saturates at RAS_DEPTH. Overflow silently overwrites the oldest entry.
  - Pop (inst_ret & ~inst_call & ~ras_empty): top decrements mod RAS_DEPTH, count decrements.
  - inst_call & inst_ret: target = top entry if non-empty, then top entry overwritten with pc+4; count unchanged. If empty, behaves as push and the target comes from jalr_src1.
  - inst_ret with RAS empty: no pop; normal jalr path, including the dependency wait.
- Flush: count and top reset to 0 (RAS contents discarded). BHT is unaffected.
- BHT update:
  - When bht_upd_vld, the counter at bht_upd_pc[BHT_IDX_W+1:2] saturates toward bht_upd_taken (00..11), written at the clock edge.
  - If a same-cycle lookup hits the same index, it uses the pre-update value.
  - Updates are honoured during flush_req but ignored during rst.
- Latency: pc changes one cycle after the qualifying edge; all outputs other than pc are combinational from pc and the current inputs.

Test Plan:
- Reset then ifetch_req held, no decode -> pc = 8000_0000, 8000_0004, 8000_0008.
- BHT training:
  - Start pc=8000_0010, bxx with imm=0x20. Before training, prdt_taken=0, next pc=8000_0014.
  - Two bht_upd taken for pc 8000_0010 -> counter 11; revisiting gives prdt_taken=1, next pc=8000_0030.
  - One not-taken update then keeps the prediction taken (counter 10).
- Call/return:
  - Call (jal) at 8000_0100 -> RAS top=8000_0104.
  - Later ret with jalr_dep=1 -> jalr_need_wait=0, ras_used=1, next pc=8000_0104, ras_empty=1 after.
- Empty-RAS ret with jalr_dep=1 for 3 cycles -> pc held 3 cycles. Then jalr_dep=0, jalr_src1=8000_0200, imm=4 -> next pc=8000_0204.
- RAS_DEPTH=4 overflow:
  - Five calls at pcs A..E -> pops return E+4, D+4, C+4, B+4.
  - ras_empty=1 after the fourth pop; the fifth ret waits on jalr_dep.
- Simultaneous events:
  - flush_req with ifetch_req and call -> pc=flush_pc, RAS empty, no push.
  - rst with flush_req -> pc=PC_DEFAULT.
  - ecall with csr_rdata=8000_0045 -> pc=8000_0044.

Source files
------------

// File: rtl/lieat_ifu_pcgen.sv
// lieat IFU next-PC generator: registered fetch PC with sequential, branch,
// jump, trap/return and flush sources, a 2-bit BHT for conditional-branch
// direction and a return address stack for call/return pairs.
module lieat_ifu_pcgen #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  PC_DEFAULT = 32'h8000_0000,
  parameter int               RAS_DEPTH  = 4,
  parameter int               BHT_IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_req,
  input  logic [XLEN-1:0]         flush_pc,
  input  logic                    ifetch_req,
  input  logic                    dec_vld,
  input  logic                    inst_jal,
  input  logic                    inst_jalr,
  input  logic                    inst_bxx,
  input  logic                    inst_ecall,
  input  logic                    inst_mret,
  input  logic                    inst_call,
  input  logic                    inst_ret,
  input  logic signed [XLEN-1:0]  imm_branch,
  input  logic [XLEN-1:0]         ifu_csr_rdata,
  input  logic                    jalr_dep,
  input  logic [XLEN-1:0]         jalr_src1,
  input  logic                    bht_upd_vld,
  input  logic [XLEN-1:0]         bht_upd_pc,
  input  logic                    bht_upd_taken,
  output logic [XLEN-1:0]         pc,
  output logic                    prdt_taken,
  output logic                    jalr_need_wait,
  output logic                    ras_used,
  output logic                    ras_empty
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BHT_N = 1 << BHT_IDX_W;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  // Fetch addresses are at least halfword aligned.
  function automatic logic [XLEN-1:0] clr_bit0(input logic [XLEN-1:0] a);
    return {a[XLEN-1:1], 1'b0};
  endfunction

  logic [XLEN-1:0]      pc_p0;
  logic [XLEN-1:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_top;
  logic [PTR_W-1:0]     ras_top_inc;
  logic [CNT_W-1:0]     ras_cnt;
  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] bht_rd_idx;
  logic [BHT_IDX_W-1:0] bht_wr_idx;
  logic                 bht_tkn;
  logic                 adv;
  logic                 ras_push;
  logic                 ras_pop;
  logic                 ras_swap;
  logic [XLEN-1:0]      pc_seq;
  logic [XLEN-1:0]      pc_tgt;
  logic                 unused_upd_pc;

  assign unused_upd_pc = ^{bht_upd_pc[XLEN-1:BHT_IDX_W+2], bht_upd_pc[1:0]};

  assign pc          = pc_p0;
  assign pc_seq      = pc_p0 + XLEN'(4);
  assign bht_rd_idx  = pc_p0[BHT_IDX_W+1:2];
  assign bht_wr_idx  = bht_upd_pc[BHT_IDX_W+1:2];
  assign bht_tkn     = bht[bht_rd_idx][1];
  assign ras_top_inc = ras_top + 1'b1;

  assign ras_empty      = (ras_cnt == '0);
  assign ras_used       = dec_vld & inst_ret & ~ras_empty;
  assign prdt_taken     = dec_vld & (inst_jal | inst_jalr | inst_ecall | inst_mret
                                     | (inst_bxx & bht_tkn));
  assign jalr_need_wait = dec_vld & inst_jalr & ~ras_used & jalr_dep;
  assign adv            = ifetch_req & ~jalr_need_wait & ~flush_req & ~rst;

  // A call+ret pair on a non-empty stack replaces the top in place; on an
  // empty stack it degenerates to a plain push.
  assign ras_push = adv & dec_vld & inst_call & (~inst_ret | ras_empty);
  assign ras_pop  = adv & dec_vld & inst_ret & ~inst_call & ~ras_empty;
  assign ras_swap = adv & dec_vld & inst_call & inst_ret & ~ras_empty;

  // Next fetch target: trap/return CSR, RAS, pc-relative, register-relative.
  always_comb begin
    pc_tgt = pc_seq;
    if (prdt_taken) begin
      if (inst_ecall | inst_mret)   pc_tgt = ifu_csr_rdata;
      else if (ras_used)            pc_tgt = ras_mem[ras_top];
      else if (inst_jal | inst_bxx) pc_tgt = pc_p0 + $unsigned(imm_branch);
      else                          pc_tgt = jalr_src1 + $unsigned(imm_branch);
    end
    pc_tgt = clr_bit0(pc_tgt);
  end

  // Stage p0: PC register and RAS pointers; flush discards the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0   <= PC_DEFAULT;
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (flush_req) begin
      pc_p0   <= flush_pc;
      ras_top <= '0;
      ras_cnt <= '0;
    end else begin
      if (adv) pc_p0 <= pc_tgt;
      if (ras_push) begin
        ras_top <= ras_top_inc;
        if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop) begin
        ras_top <= ras_top - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  // Return-address storage; overflow overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (ras_push)      ras_mem[ras_top_inc] <= pc_seq;
    else if (ras_swap) ras_mem[ras_top]     <= pc_seq;
  end

  // Branch history: counters train on resolved branches, also during flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (bht_upd_vld) begin
      bht[bht_wr_idx] <= sat_cnt(bht[bht_wr_idx], bht_upd_taken);
    end
  end

endmodule

// File: tb/tb_lieat_ifu_pcgen.sv
// Self-checking bench for lieat_ifu_pcgen: directed scenarios followed by
// randomized traffic, all compared against a queue/array reference model.
module tb_lieat_ifu_pcgen;

  localparam int          XLEN  = 32;
  localparam logic [31:0] PCDEF = 32'h8000_0000;
  localparam int          DEPTH = 4;
  localparam int          IDXW  = 4;

  logic clk = 1'b0;
  logic rst, flush_req, ifetch_req, dec_vld;
  logic inst_jal, inst_jalr, inst_bxx, inst_ecall, inst_mret, inst_call, inst_ret;
  logic jalr_dep, bht_upd_vld, bht_upd_taken;
  logic [31:0] flush_pc, imm_branch, ifu_csr_rdata, jalr_src1, bht_upd_pc;
  logic [31:0] pc;
  logic prdt_taken, jalr_need_wait, ras_used, ras_empty;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_bht [1 << IDXW];
  logic [31:0] m_ras [$];
  bit          m_init = 0;

  always #5 clk = ~clk;

  lieat_ifu_pcgen #(.XLEN(XLEN), .PC_DEFAULT(PCDEF), .RAS_DEPTH(DEPTH), .BHT_IDX_W(IDXW)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_pc(flush_pc),
    .ifetch_req(ifetch_req), .dec_vld(dec_vld), .inst_jal(inst_jal),
    .inst_jalr(inst_jalr), .inst_bxx(inst_bxx), .inst_ecall(inst_ecall),
    .inst_mret(inst_mret), .inst_call(inst_call), .inst_ret(inst_ret),
    .imm_branch(imm_branch), .ifu_csr_rdata(ifu_csr_rdata), .jalr_dep(jalr_dep),
    .jalr_src1(jalr_src1), .bht_upd_vld(bht_upd_vld), .bht_upd_pc(bht_upd_pc),
    .bht_upd_taken(bht_upd_taken), .pc(pc), .prdt_taken(prdt_taken),
    .jalr_need_wait(jalr_need_wait), .ras_used(ras_used), .ras_empty(ras_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_dec();
    dec_vld = 0; inst_jal = 0; inst_jalr = 0; inst_bxx = 0;
    inst_ecall = 0; inst_mret = 0; inst_call = 0; inst_ret = 0;
  endtask

  // Called just after a falling edge with inputs driven: checks the
  // combinational outputs, advances the model, then checks pc after the edge.
  task automatic step();
    int          idx;
    bit          tkn, ru, ptk, wt, adv;
    logic [31:0] tgt;
    #1;
    idx = int'((m_pc >> 2) & ((1 << IDXW) - 1));
    tkn = (m_bht[idx] >= 2);
    ru  = dec_vld && inst_ret && (m_ras.size() != 0);
    ptk = dec_vld && (inst_jal || inst_jalr || inst_ecall || inst_mret || (inst_bxx && tkn));
    wt  = dec_vld && inst_jalr && !ru && jalr_dep;
    adv = ifetch_req && !wt && !flush_req && !rst;
    if (m_init) begin
      check("ras_used", 32'(ras_used), 32'(ru));
      check("prdt_taken", 32'(prdt_taken), 32'(ptk));
      check("jalr_need_wait", 32'(jalr_need_wait), 32'(wt));
      check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    end
    if (!ptk)                        tgt = m_pc + 4;
    else if (inst_ecall || inst_mret) tgt = ifu_csr_rdata;
    else if (ru)                     tgt = m_ras[$];
    else if (inst_jal || inst_bxx)   tgt = m_pc + imm_branch;
    else                             tgt = jalr_src1 + imm_branch;
    tgt[0] = 1'b0;
    if (rst) begin
      m_pc = PCDEF;
      m_ras.delete();
      foreach (m_bht[i]) m_bht[i] = 1;
      m_init = 1;
    end else begin
      if (flush_req) begin
        m_pc = flush_pc;
        m_ras.delete();
      end else if (adv) begin
        if (dec_vld) begin
          if (inst_call && inst_ret && m_ras.size() != 0) m_ras[$] = m_pc + 4;
          else if (inst_call) begin
            m_ras.push_back(m_pc + 4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          end else if (inst_ret && m_ras.size() != 0) void'(m_ras.pop_back());
        end
        m_pc = tgt;
      end
      if (bht_upd_vld) begin
        idx = int'((bht_upd_pc >> 2) & ((1 << IDXW) - 1));
        if (bht_upd_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else               m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      end
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    @(negedge clk);
  endtask

  task automatic do_flush(input logic [31:0] target);
    clr_dec(); ifetch_req = 0; bht_upd_vld = 0;
    flush_req = 1; flush_pc = target;
    step();
    flush_req = 0;
  endtask

  task automatic set_ret(input bit dep);
    clr_dec(); dec_vld = 1; inst_jalr = 1; inst_ret = 1; jalr_dep = dep;
  endtask

  initial begin
    logic [31:0] r;
    int          k;
    rst = 1; flush_req = 0; flush_pc = '0; ifetch_req = 0; clr_dec();
    imm_branch = '0; ifu_csr_rdata = '0; jalr_dep = 0; jalr_src1 = '0;
    bht_upd_vld = 0; bht_upd_pc = '0; bht_upd_taken = 0;
    @(negedge clk);

    // reset and sequential fetch
    step();
    check("reset_pc", pc, 32'h8000_0000);
    check("reset_ras_empty", 32'(ras_empty), 32'd1);
    rst = 0; ifetch_req = 1;
    step(); check("seq_pc1", pc, 32'h8000_0004);
    step(); check("seq_pc2", pc, 32'h8000_0008);

    // BHT training
    do_flush(32'h8000_0010);
    dec_vld = 1; inst_bxx = 1; imm_branch = 32'h20; ifetch_req = 1;
    #1 check("bht_cold_prdt", 32'(prdt_taken), 32'd0);
    step(); check("bht_cold_pc", pc, 32'h8000_0014);
    clr_dec(); ifetch_req = 0;
    bht_upd_vld = 1; bht_upd_pc = 32'h8000_0010; bht_upd_taken = 1;
    step(); step();
    do_flush(32'h8000_0010);
    dec_vld = 1; inst_bxx = 1; ifetch_req = 1;
    #1 check("bht_hot_prdt", 32'(prdt_taken), 32'd1);
    step(); check("bht_hot_pc", pc, 32'h8000_0030);
    clr_dec(); ifetch_req = 0;
    bht_upd_vld = 1; bht_upd_taken = 0;
    step();
    do_flush(32'h8000_0010);
    dec_vld = 1; inst_bxx = 1;
    #1 check("bht_weak_prdt", 32'(prdt_taken), 32'd1);
    step();

    // call then return through the RAS despite a register dependency
    do_flush(32'h8000_0100);
    dec_vld = 1; inst_jal = 1; inst_call = 1; imm_branch = 32'h40; ifetch_req = 1;
    step(); check("call_pc", pc, 32'h8000_0140);
    set_ret(1);
    #1 check("ret_wait", 32'(jalr_need_wait), 32'd0);
    check("ret_ras_used", 32'(ras_used), 32'd1);
    step(); check("ret_pc", pc, 32'h8000_0104);
    check("ret_ras_empty", 32'(ras_empty), 32'd1);

    // empty-RAS return stalls on the dependency
    jalr_src1 = 32'h8000_0200; imm_branch = 32'h4;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_wait", 32'(jalr_need_wait), 32'd1);
      step(); check("hold_pc", pc, 32'h8000_0104);
    end
    jalr_dep = 0;
    step(); check("jalr_pc", pc, 32'h8000_0204);

    // RAS overflow: five calls, four successful pops
    do_flush(32'h8000_1000);
    ifetch_req = 1; imm_branch = 32'h100;
    for (int i = 0; i < 5; i++) begin
      clr_dec(); dec_vld = 1; inst_jal = 1; inst_call = 1;
      step();
    end
    for (int i = 4; i >= 1; i--) begin
      set_ret(1);
      step(); check("ovf_ret_pc", pc, 32'h8000_1004 + 32'(i) * 32'h100);
    end
    check("ovf_empty", 32'(ras_empty), 32'd1);
    #1 check("ovf_fifth_wait", 32'(jalr_need_wait), 32'd1);
    step();

    // simultaneous events
    clr_dec(); dec_vld = 1; inst_jal = 1; inst_call = 1; ifetch_req = 1;
    flush_req = 1; flush_pc = 32'h8000_0300;
    step(); check("flush_call_pc", pc, 32'h8000_0300);
    check("flush_call_empty", 32'(ras_empty), 32'd1);
    rst = 1;
    step(); check("rst_flush_pc", pc, 32'h8000_0000);
    rst = 0; flush_req = 0;
    clr_dec(); dec_vld = 1; inst_ecall = 1; ifu_csr_rdata = 32'h8000_0045;
    step(); check("ecall_pc", pc, 32'h8000_0044);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clr_dec();
      rst        = ($urandom_range(0, 99) < 1);
      flush_req  = ($urandom_range(0, 99) < 4);
      flush_pc   = $urandom & 32'hFFFF_FFFC;
      ifetch_req = ($urandom_range(0, 99) < 85);
      dec_vld    = ($urandom_range(0, 99) < 75);
      k = $urandom_range(0, 5);
      case (k)
        1: begin inst_jal = 1; inst_call = $urandom_range(0, 1); end
        2: begin inst_jalr = 1; inst_call = $urandom_range(0, 1); inst_ret = $urandom_range(0, 1); end
        3: inst_bxx = 1;
        4: inst_ecall = 1;
        5: inst_mret = 1;
        default: ;
      endcase
      r = $urandom;
      imm_branch    = {{20{r[11]}}, r[11:1], 1'b0};
      ifu_csr_rdata = $urandom;
      jalr_src1     = $urandom;
      jalr_dep      = ($urandom_range(0, 99) < 30);
      bht_upd_vld   = ($urandom_range(0, 1) == 1);
      bht_upd_pc    = ($urandom_range(0, 1) == 1) ? pc : $urandom;
      bht_upd_taken = ($urandom_range(0, 99) < 60);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
